// File: rtl/display_pkg.sv
// display_pkg: shared 7-segment constants and the active-low hex glyph lookup.
package display_pkg;
  localparam int DIGITS = 8;
  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [3:0] BLANK_NIBBLE = 4'hF;

  // Patterns are {g,f,e,d,c,b,a}, active low; 4'hF is reserved as blank
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    case (nib)
      4'h0: hex_to_seg = 7'h40;
      4'h1: hex_to_seg = 7'h79;
      4'h2: hex_to_seg = 7'h24;
      4'h3: hex_to_seg = 7'h30;
      4'h4: hex_to_seg = 7'h19;
      4'h5: hex_to_seg = 7'h12;
      4'h6: hex_to_seg = 7'h02;
      4'h7: hex_to_seg = 7'h78;
      4'h8: hex_to_seg = 7'h00;
      4'h9: hex_to_seg = 7'h10;
      4'hA: hex_to_seg = 7'h08;
      4'hB: hex_to_seg = 7'h03;
      4'hC: hex_to_seg = 7'h46;
      4'hD: hex_to_seg = 7'h21;
      4'hE: hex_to_seg = 7'h06;
      default: hex_to_seg = SEG_OFF;
    endcase
  endfunction
endpackage

// File: rtl/button_debouncer.sv
// button_debouncer: synchronises a raw button and accepts a new level only after
// it has held steady for DEBOUNCE_CYC cycles; btn_rise pulses on an accepted press.
module button_debouncer #(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE_CYC = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_rise
);
  localparam int CW = DEBOUNCE_CYC > 1 ? $clog2(DEBOUNCE_CYC) : 1;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0] r_cnt;
  logic r_level, r_rise;
  logic w_synced, w_diff, w_done;
  assign w_synced = r_sync[SYNC_STAGES-1];
  assign w_diff = w_synced != r_level;
  assign w_done = w_diff && r_cnt == CW'(DEBOUNCE_CYC - 1);
  assign btn_level = r_level;
  assign btn_rise = r_rise;
  // Any cycle where synced matches the accepted level restarts the count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_cnt <= '0;
      r_level <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_sync <= (r_sync << 1) | SYNC_STAGES'(btn_raw);
      r_cnt <= (w_diff && !w_done) ? r_cnt + CW'(1) : '0;
      r_level <= w_done ? w_synced : r_level;
      r_rise <= w_done && w_synced;
    end
  end
endmodule

// File: rtl/multi_channel_display_scanner.sv
// multi_channel_display_scanner: 8-digit scanner showing channels mode/mode+1 with guard time.
// Define LZ_BLANK_EN to blank leading zeros within each 4-digit half.
module multi_channel_display_scanner
  import display_pkg::*;
#(
  parameter int NUM_CH = 3,
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD_CYC = 2,
  parameter int DEBOUNCE_CYC = 1000000,
  localparam int MODE_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   btn_mode,
  input  logic [16*NUM_CH-1:0]   chan_data,
  output logic [6:0]             segments,
  output logic [DIGITS-1:0]      anodes,
  output logic [MODE_W-1:0]      mode
);
  localparam int PW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
  logic [PW-1:0] r_presc;
  logic [2:0] r_digit;
  logic [3:0] r_nib;
  logic [6:0] r_seg;
  logic [DIGITS-1:0] r_an;
  logic [MODE_W-1:0] r_mode;
  logic w_btn_level, w_btn_rise, w_step, w_wrap, w_guard, w_left_off, w_lz;
  int w_sel, w_ci;
  logic [15:0] w_word;
  logic [3:0] w_raw, w_nib, w_cur;

  button_debouncer #(.SYNC_STAGES(2), .DEBOUNCE_CYC(DEBOUNCE_CYC)) u_btn (
    .clk(clk),
    .rst_n(rst_n),
    .btn_raw(btn_mode),
    .btn_level(w_btn_level),
    .btn_rise(w_btn_rise)
  );

  assign w_step = w_btn_rise && w_btn_level;
  assign w_wrap = r_presc == PW'(REFRESH_DIV - 1);
  assign w_guard = int'(r_presc) < GUARD_CYC;
  assign w_sel = int'(r_mode) + int'(r_digit[2]);
  assign w_left_off = w_sel >= NUM_CH;
  assign w_ci = w_left_off ? 0 : w_sel;
  assign w_word = chan_data[16*w_ci +: 16];
  assign w_raw = w_word[{r_digit[1:0], 2'b00} +: 4];
`ifdef LZ_BLANK_EN
  // Leading zero: this nibble and every one above it in the half is zero; nibble 0 always shows
  assign w_lz = r_digit[1:0] != 2'd0 && (w_word >> {r_digit[1:0], 2'b00}) == 16'h0;
`else
  assign w_lz = 1'b0;
`endif
  assign w_nib = (w_left_off || w_lz) ? BLANK_NIBBLE : w_raw;
  assign w_cur = r_presc == '0 ? w_nib : r_nib;

  assign segments = r_seg;
  assign anodes = r_an;
  assign mode = r_mode;

  // The nibble is frozen at slot start so mid-slot data or mode changes cannot tear the digit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_digit <= 3'd0;
      r_nib <= BLANK_NIBBLE;
      r_seg <= SEG_OFF;
      r_an <= '1;
      r_mode <= '0;
    end else begin
      r_presc <= w_wrap ? '0 : r_presc + PW'(1);
      r_digit <= w_wrap ? r_digit + 3'd1 : r_digit;
      r_nib <= r_presc == '0 ? w_nib : r_nib;
      r_an <= w_guard ? '1 : ~(DIGITS'(1) << r_digit);
      r_seg <= w_guard ? SEG_OFF : hex_to_seg(w_cur);
      r_mode <= !w_step ? r_mode : r_mode == MODE_W'(NUM_CH - 1) ? '0 : r_mode + MODE_W'(1);
    end
  end
endmodule

// File: tb/tb_multi_channel_display_scanner.sv
// tb_multi_channel_display_scanner: directed scoreboard bench for the scanner
// (NUM_CH=3, REFRESH_DIV=8, GUARD_CYC=2, DEBOUNCE_CYC=4).
module tb_multi_channel_display_scanner;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn = 1'b0;
  logic [47:0] chan;
  logic [6:0] seg;
  logic [7:0] an;
  logic [1:0] mode;
  int checks = 0;
  int errors = 0;
  int pc = 0;
  int p;
  logic [14:0] exp_q[$];
  logic [6:0] G [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                         7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h7F};

  always #5 clk = ~clk;

  // pc = number of rising edges since reset release
  always @(posedge clk or negedge rst_n)
    if (!rst_n) pc <= 0;
    else pc <= pc + 1;

  multi_channel_display_scanner #(
    .NUM_CH(3), .REFRESH_DIV(8), .GUARD_CYC(2), .DEBOUNCE_CYC(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_mode(btn),
    .chan_data(chan),
    .segments(seg),
    .anodes(an),
    .mode(mode)
  );

  task automatic chk(input string tag, input logic [14:0] obs, input logic [14:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic wait_pc(input int target);
    int n = 0;
    while (pc < target && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (pc < target) chk("timeout", 15'(pc), 15'(target));
  endtask

  task automatic expect_at(input int target, input string tag, input logic [7:0] a, input logic [6:0] sg);
    exp_q.push_back({a, sg});
    wait_pc(target);
    chk(tag, {an, seg}, exp_q.pop_front());
  endtask

  // First non-guard output cycle of digit slot sl, at least lead cycles from now
  task automatic check_slot(input int sl, input int lead, input string tag, input logic [7:0] a, input logic [6:0] sg);
    int t = pc + lead + 1;
    while (((t - 1) % 64) != 8 * sl + 2) t++;
    expect_at(t, tag, a, sg);
  endtask

  task automatic press(input int n);
    btn = 1'b1;
    repeat (n) @(negedge clk);
    btn = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  initial begin
    chan = {16'h9ABC, 16'h5678, 16'h1234};
    repeat (3) @(negedge clk);
    chk("rst_seg", 15'(seg), 15'h7F);
    chk("rst_an", 15'(an), 15'hFF);
    chk("rst_mode", 15'(mode), 15'h0);
    rst_n = 1'b1;
    wait_pc(1); chk("guard1", 15'(an), 15'hFF);
    wait_pc(2); chk("guard2", 15'(an), 15'hFF);
    expect_at(3, "slot0", 8'hFE, G[4]);
    expect_at(11, "slot1", 8'hFD, G[3]);
    wait_pc(33); chk("guard_s4", 15'(an), 15'hFF);
    expect_at(35, "slot4", 8'hEF, G[8]);
    expect_at(59, "slot7", 8'h7F, G[5]);
    btn = 1'b1;
    repeat (2) @(negedge clk);
    btn = 1'b0;
    repeat (12) @(negedge clk);
    chk("bounce_mode", 15'(mode), 15'h0);
    press(10);
    chk("mode1", 15'(mode), 15'h1);
    check_slot(0, 9, "m1_slot0", 8'hFE, G[8]);
    check_slot(3, 9, "m1_slot3", 8'hF7, G[5]);
    check_slot(5, 9, "m1_slot5", 8'hDF, G[11]);
    press(10);
    chk("mode2", 15'(mode), 15'h2);
    check_slot(0, 9, "m2_slot0", 8'hFE, G[12]);
    check_slot(6, 9, "m2_slot6_blank", 8'hBF, 7'h7F);
    press(10);
    chk("mode_wrap", 15'(mode), 15'h0);
    check_slot(0, 9, "m0_slot0", 8'hFE, G[4]);
    p = pc + 1;
    while (p % 64 != 5) p++;
    wait_pc(p);
    chan[15:0] = 16'h9999;
    expect_at(p + 1, "tear_keep", 8'hFE, G[4]);
    check_slot(1, 0, "tear_next", 8'hFD, G[9]);
    press(10);
    chk("mode1_again", 15'(mode), 15'h1);
    p = pc + 1;
    while (p % 64 != 28) p++;
    expect_at(p, "pre_rst_slot3", 8'hF7, G[5]);
    rst_n = 1'b0;
    #1;
    chk("async_seg", 15'(seg), 15'h7F);
    chk("async_an", 15'(an), 15'hFF);
    chk("async_mode", 15'(mode), 15'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_pc(2); chk("rst_guard", 15'(an), 15'hFF);
    expect_at(3, "rst_slot0", 8'hFE, G[9]);
    chan[15:0] = 16'h0042;
`ifdef LZ_BLANK_EN
    check_slot(0, 9, "lz42_s0", 8'hFE, G[2]);
    check_slot(1, 9, "lz42_s1", 8'hFD, G[4]);
    check_slot(2, 9, "lz42_s2", 8'hFB, 7'h7F);
    check_slot(3, 9, "lz42_s3", 8'hF7, 7'h7F);
    chan[15:0] = 16'h0000;
    check_slot(0, 9, "lz0_s0", 8'hFE, G[0]);
    check_slot(1, 9, "lz0_s1", 8'hFD, 7'h7F);
    check_slot(3, 9, "lz0_s3", 8'hF7, 7'h7F);
`else
    check_slot(0, 9, "lit42_s0", 8'hFE, G[2]);
    check_slot(1, 9, "lit42_s1", 8'hFD, G[4]);
    check_slot(2, 9, "lit42_s2", 8'hFB, G[0]);
    check_slot(3, 9, "lit42_s3", 8'hF7, G[0]);
    chan[15:0] = 16'h0000;
    check_slot(0, 9, "lit0_s0", 8'hFE, G[0]);
    check_slot(3, 9, "lit0_s3", 8'hF7, G[0]);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
